seq_frame_loader: RTL and testbench
===================================

SEQ_FRAME_LOADER -- requirements
Module: seq_frame_loader

Interface
REQ-001 SHALL have parameter SEQ_LEN, default 4, tokens per frame.
REQ-002 SHALL have parameter EMBED_DIM, default 8, elements per token.
REQ-003 SHALL have parameter DATA_W, default 16, signed element width.
REQ-004 SHALL have parameter POS_STEP, default 0, signed positional bias added per row index.
REQ-005 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have in_valid  input  1  streamed element present.
REQ-008 SHALL have in_data  input  DATA_W signed  element value, row-major order.
REQ-009 SHALL have in_last  input  1  marks the final element of a sequence.
REQ-010 SHALL have in_ready  output  1  loader accepts an element this cycle.
REQ-011 SHALL have enc_done  input  1  downstream encoder valid_out.
REQ-012 SHALL have x_out  output  [SEQ_LEN][EMBED_DIM] x DATA_W signed  assembled frame, drives encoder x.
REQ-013 SHALL have frame_valid  output  1  drives encoder valid_in; one-cycle pulse.
REQ-014 SHALL have err  output  1  one-cycle pulse on malformed sequence.
REQ-015 SHALL have frame_count  output  8  frames issued, wraps 255->0.

Function
REQ-016 SHALL implement FSM states FILL, ISSUE, WAIT.
REQ-017 SHALL drive in_ready=1 only in FILL; accept = in_valid && in_ready.
REQ-018 SHALL keep element index idx 0..SEQ_LEN*EMBED_DIM-1; on accept write x_out[idx/EMBED_DIM][idx%EMBED_DIM], then idx+1.
REQ-019 SHALL store sat(in_data + row*POS_STEP), sum computed at DATA_W+8 bits, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-020 SHALL leave idx and x_out unchanged in cycles without accept (gaps in in_valid allowed).
REQ-021 SHALL transition FILL->ISSUE on the accept of element idx=SEQ_LEN*EMBED_DIM-1, whether or not in_last is set.
REQ-022 SHALL assert frame_valid for exactly the ISSUE cycle (1 cycle after final accept), increment frame_count in that cycle, then go to WAIT.
REQ-023 SHALL hold x_out stable from ISSUE until leaving WAIT.
REQ-024 SHALL, in WAIT, on enc_done=1 go to FILL next cycle with idx=0; enc_done in FILL or ISSUE is ignored.
REQ-025 SHALL, on accept with in_last=1 and idx<final, discard the partial frame: pulse err next cycle, idx=0, stay in FILL, no frame_valid.
REQ-026 SHALL not clear x_out on abort; stale elements are overwritten by the next fill.
REQ-027 SHALL drive all outputs from registers except in_ready, which is decoded from state.

Reset
REQ-028 SHALL on rst=1 immediately force state=FILL, idx=0, frame_valid=0, err=0, frame_count=0, all x_out=0, in_ready=1 after release.
REQ-029 SHALL, if rst asserts mid-FILL or in WAIT, discard the frame and issue no frame_valid after release.

Verification
REQ-030 SHALL cover: 32 back-to-back accepts of (i+1)*(j+2), POS_STEP=0 -> frame_valid single pulse 1 cycle after 32nd accept, x_out[0][0]=2, x_out[3][7]=36, frame_count=1.
REQ-031 SHALL cover: POS_STEP=16384, all in_data=20000 -> row0=20000, rows1..3=32767; with in_data=-32768, POS_STEP=-1 -> row1..3=-32768.
REQ-032 SHALL cover: in_last on 10th accept -> err pulse next cycle, no frame_valid, next accepted value lands in x_out[0][0].
REQ-033 SHALL cover: in WAIT with in_valid held high for 20 cycles -> in_ready=0, x_out unchanged; enc_done pulse -> in_ready=1 next cycle.
REQ-034 SHALL cover: in_valid toggling every other cycle -> same frame as REQ-030, frame_valid 1 cycle after final accept.
REQ-035 SHALL cover: rst asserted after 15 accepts -> x_out all 0, frame_count 0, fresh 32-element fill produces correct frame.

Source files
------------

// File: rtl/seq_frame_loader.sv
// Streams row-major tokens into a SEQ_LEN x EMBED_DIM frame with positional bias,
// then issues the frame to an encoder and waits for its completion.
// Ports:
//   clk, rst                  clock, async active-high reset
//   in_valid/in_data/in_last  element stream input; in_ready back-pressure
//   enc_done                  encoder finished with the issued frame
//   x_out                     assembled frame (registered)
//   frame_valid               one-cycle issue pulse
//   err                       one-cycle pulse when a sequence ends early
//   frame_count               frames issued, wraps at 256
module seq_frame_loader #(
  parameter int SEQ_LEN   = 4,
  parameter int EMBED_DIM = 8,
  parameter int DATA_W    = 16,
  parameter int POS_STEP  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     in_ready,
  input  logic                     enc_done,
  output logic signed [SEQ_LEN-1:0][EMBED_DIM-1:0][DATA_W-1:0] x_out,
  output logic                     frame_valid,
  output logic                     err,
  output logic [7:0]               frame_count
);

  localparam int RB = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int CB = (EMBED_DIM > 1) ? $clog2(EMBED_DIM) : 1;
  localparam int RW = DATA_W + 8;

  localparam logic signed [RW-1:0] STEP = RW'(POS_STEP);
  localparam logic signed [RW-1:0] MAXV =
    RW'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] MINV = -MAXV - RW'(1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            r_state;
  logic [RB-1:0]     r_row;
  logic [CB-1:0]     r_col;
  logic signed [SEQ_LEN-1:0][EMBED_DIM-1:0][DATA_W-1:0] r_x;
  logic              r_fv;
  logic              r_err;
  logic [7:0]        r_cnt;

  logic                     w_acc;
  logic                     w_final;
  logic                     w_row_end;
  logic signed [RW-1:0]     w_row_s;
  logic signed [RW-1:0]     w_bias;
  logic signed [RW-1:0]     w_sum;
  logic signed [DATA_W-1:0] w_sat;

  assign in_ready  = (r_state == S_FILL);
  assign w_acc     = in_valid && in_ready;
  assign w_row_end = (r_col == CB'(EMBED_DIM - 1));
  assign w_final   = w_row_end && (r_row == RB'(SEQ_LEN - 1));

  // Widened sum so row*POS_STEP cannot wrap before clamping.
  assign w_row_s = RW'(r_row);
  assign w_bias  = w_row_s * STEP;
  assign w_sum   = RW'(in_data) + w_bias;

  always_comb begin
    w_sat = w_sum[DATA_W-1:0];
    if (w_sum > MAXV) begin
      w_sat = MAXV[DATA_W-1:0];
    end else if (w_sum < MINV) begin
      w_sat = MINV[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FILL;
      r_row   <= '0;
      r_col   <= '0;
      r_x     <= '0;
      r_fv    <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_fv  <= 1'b0;
      r_err <= 1'b0;
      unique case (r_state)
        S_FILL: begin
          if (w_acc) begin
            r_x[r_row][r_col] <= w_sat;
            if (w_final) begin
              // Pulse and count land in the ISSUE cycle.
              r_row   <= '0;
              r_col   <= '0;
              r_fv    <= 1'b1;
              r_cnt   <= r_cnt + 8'd1;
              r_state <= S_ISSUE;
            end else if (in_last) begin
              // Short sequence: drop it, stale data is overwritten later.
              r_row <= '0;
              r_col <= '0;
              r_err <= 1'b1;
            end else if (w_row_end) begin
              r_col <= '0;
              r_row <= r_row + RB'(1);
            end else begin
              r_col <= r_col + CB'(1);
            end
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (enc_done) begin
            r_state <= S_FILL;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign x_out       = r_x;
  assign frame_valid = r_fv;
  assign err         = r_err;
  assign frame_count = r_cnt;

endmodule

// File: tb/tb_seq_frame_loader.sv
// Bench for seq_frame_loader: three instances with different positional
// steps share one stimulus stream and are checked against a frame model.
module tb_seq_frame_loader;

  localparam int S = 4;
  localparam int E = 8;
  localparam int N = S * E;
  localparam int STEPS [3] = '{0, 16384, -1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic signed [15:0] in_data = '0;
  logic in_last = 1'b0;
  logic enc_done = 1'b0;

  logic rdy [3];
  logic fv [3];
  logic er [3];
  logic [7:0] fc [3];
  logic [S-1:0][E-1:0][15:0] xo [3];

  int checks = 0;
  int errors = 0;
  bit en = 1'b0;

  always #5 clk = ~clk;

  seq_frame_loader #(.POS_STEP(STEPS[0])) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(rdy[0]), .enc_done(enc_done),
    .x_out(xo[0]), .frame_valid(fv[0]), .err(er[0]),
    .frame_count(fc[0])
  );

  seq_frame_loader #(.POS_STEP(STEPS[1])) u_pos (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(rdy[1]), .enc_done(enc_done),
    .x_out(xo[1]), .frame_valid(fv[1]), .err(er[1]),
    .frame_count(fc[1])
  );

  seq_frame_loader #(.POS_STEP(STEPS[2])) u_neg (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(rdy[2]), .enc_done(enc_done),
    .x_out(xo[2]), .frame_valid(fv[2]), .err(er[2]),
    .frame_count(fc[2])
  );

  // Model: phase 0 loading, 1 issuing, 2 held for encoder.
  int m_ph = 0;
  int m_cnt = 0;
  bit m_fv = 1'b0;
  bit m_er = 1'b0;
  int m_fc = 0;
  int m_fr [3][N];

  function automatic int sat16(input int s);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph  <= 0;
      m_cnt <= 0;
      m_fv  <= 1'b0;
      m_er  <= 1'b0;
      m_fc  <= 0;
      for (int k = 0; k < 3; k++)
        for (int e = 0; e < N; e++)
          m_fr[k][e] <= 0;
    end else begin
      m_fv <= 1'b0;
      m_er <= 1'b0;
      if (m_ph == 0) begin
        if (in_valid) begin
          for (int k = 0; k < 3; k++)
            m_fr[k][m_cnt] <=
              sat16(int'(in_data) + (m_cnt / E) * STEPS[k]);
          if (m_cnt == N - 1) begin
            m_cnt <= 0;
            m_ph  <= 1;
            m_fv  <= 1'b1;
            m_fc  <= (m_fc + 1) % 256;
          end else if (in_last) begin
            m_cnt <= 0;
            m_er  <= 1'b1;
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
      end else if (m_ph == 1) begin
        m_ph <= 2;
      end else if (enc_done) begin
        m_ph <= 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("in_ready[%0d]", k), int'(rdy[k]), int'(m_ph == 0));
        chk($sformatf("frame_valid[%0d]", k), int'(fv[k]), int'(m_fv));
        chk($sformatf("err[%0d]", k), int'(er[k]), int'(m_er));
        chk($sformatf("frame_count[%0d]", k), int'(fc[k]), m_fc);
        for (int r = 0; r < S; r++)
          for (int c = 0; c < E; c++)
            chk($sformatf("x_out[%0d][%0d][%0d]", k, r, c),
                int'($signed(xo[k][r][c])), m_fr[k][r*E+c]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v, input bit last);
    int n;
    n = 0;
    while (!rdy[0] && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) chk("ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_data  = 16'(v);
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic fill(input int mode, input bit gap);
    int v;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < E; j++) begin
        v = (mode == 0) ? (i + 1) * (j + 2) :
            (mode == 1) ? 20000 : -32768;
        push(v, (i == S - 1) && (j == E - 1));
        if (gap && !((i == S - 1) && (j == E - 1))) tick();
      end
    chk("fv_after_final", int'(fv[0]), 1);
    tick();
    chk("fv_single_pulse", int'(fv[0]), 0);
    chk("ready_in_wait", int'(rdy[0]), 0);
  endtask

  task automatic release_enc();
    enc_done = 1'b1;
    tick();
    enc_done = 1'b0;
    chk("ready_after_done", int'(rdy[0]), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tick();
    tick();
    en = 1'b1;
    chk("rst_count", int'(fc[0]), 0);
    chk("rst_x00", int'($signed(xo[0][0][0])), 0);
    rst = 1'b0;
    tick();
    chk("rst_ready", int'(rdy[0]), 1);

    fill(0, 1'b0);
    chk("x00", int'($signed(xo[0][0][0])), 2);
    chk("x37", int'($signed(xo[0][3][7])), 36);
    chk("count1", int'(fc[0]), 1);
    chk("neg_x37", int'($signed(xo[2][3][7])), 33);

    in_valid = 1'b1;
    in_data  = 16'sd999;
    repeat (20) begin
      tick();
      chk("wait_ready", int'(rdy[0]), 0);
    end
    in_valid = 1'b0;
    chk("wait_x00", int'($signed(xo[0][0][0])), 2);
    chk("wait_x37", int'($signed(xo[0][3][7])), 36);
    release_enc();

    fill(0, 1'b1);
    chk("gap_x00", int'($signed(xo[0][0][0])), 2);
    chk("gap_x37", int'($signed(xo[0][3][7])), 36);
    chk("count2", int'(fc[0]), 2);
    release_enc();

    for (int k = 0; k < 9; k++) push(100 + k, 1'b0);
    push(109, 1'b1);
    chk("abort_err", int'(er[0]), 1);
    chk("abort_nofv", int'(fv[0]), 0);
    tick();
    chk("abort_err_pulse", int'(er[0]), 0);
    push(77, 1'b0);
    chk("abort_restart", int'($signed(xo[0][0][0])), 77);
    chk("abort_stale", int'($signed(xo[0][0][1])), 101);

    for (int k = 0; k < 14; k++) push(200 + k, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_x00", int'($signed(xo[0][0][0])), 0);
    chk("mid_rst_count", int'(fc[0]), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_nofv", int'(fv[0]), 0);

    fill(0, 1'b0);
    chk("fresh_x00", int'($signed(xo[0][0][0])), 2);
    chk("fresh_x37", int'($signed(xo[0][3][7])), 36);
    chk("fresh_count", int'(fc[0]), 1);
    release_enc();

    fill(1, 1'b0);
    chk("pos_row0", int'($signed(xo[1][0][0])), 20000);
    chk("pos_row1", int'($signed(xo[1][1][0])), 32767);
    chk("pos_row3", int'($signed(xo[1][3][7])), 32767);
    release_enc();

    fill(2, 1'b0);
    chk("neg_row0", int'($signed(xo[2][0][0])), -32768);
    chk("neg_row1", int'($signed(xo[2][1][0])), -32768);
    chk("neg_row3", int'($signed(xo[2][3][7])), -32768);
    chk("pos_neg_row1", int'($signed(xo[1][1][0])), -16384);
    chk("count3", int'(fc[0]), 3);
    release_enc();

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
